video_ulaplus_port: RTL and testbench

CPU-side writer for the ULAplus palette and mode registers. Decodes Z80 accesses to the register-select port (#BF3B) and data port (#FF3B) into the `up_ena`, `up_palwr`, `up_paladdr` and `up_paldata` signals consumed by the palette/frame mixer. Defers palette writes around colliding ATM palette writes, which take priority in the mixer. Optionally keeps a shadow copy of the 64 ULAplus entries for 8-bit readback.

---
 rtl/video_ulaplus_port_pkg.sv | 23 ++
 rtl/video_ulaplus_shadow.sv | 38 +++
 rtl/video_ulaplus_port.sv | 174 +++++++++++++++++
 tb/tb_video_ulaplus_port.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/video_ulaplus_port_pkg.sv
// -----------------------------------------------------------------------------
// video_ulaplus_port_pkg
// Shared constants for the ULAplus CPU-side port writer and its shadow RAM.
//   - register-group codes held in regsel[7:6]
//   - port selector values (#BF3B register select, #FF3B data)
//   - readback idle value and palette geometry
// Configuration macro used by the files importing this package:
//   ULAPLUS_READBACK_EN (shadow RAM and bypass readback present when defined)
// -----------------------------------------------------------------------------
package video_ulaplus_port_pkg;

   localparam logic [1:0] UP_GRP_PAL  = 2'b00;
   localparam logic [1:0] UP_GRP_MODE = 2'b01;

   localparam logic UP_SEL_REG  = 1'b0;   // #BF3B
   localparam logic UP_SEL_DATA = 1'b1;   // #FF3B

   localparam logic [7:0] UP_RD_IDLE = 8'hFF;

   localparam int UP_IDX_W     = 6;
   localparam int UP_PAL_DEPTH = 1 << UP_IDX_W;

endpackage

// File: rtl/video_ulaplus_shadow.sv
// -----------------------------------------------------------------------------
// video_ulaplus_shadow
// 64x8 shadow copy of the ULAplus palette: one write port, one registered
// read port, written as a plain array so it maps onto block RAM.
// Contents are deliberately not reset.
// Only instantiated when ULAPLUS_READBACK_EN is defined.
// Ports:
//   clk    in  1  clock
//   we     in  1  write enable (palette commit)
//   waddr  in  6  write index
//   wdata  in  8  write data
//   raddr  in  6  read index, presented one cycle before rdata
//   rdata  out 8  registered read data (read-before-write on collision)
// -----------------------------------------------------------------------------
module video_ulaplus_shadow
   import video_ulaplus_port_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [UP_IDX_W-1:0] waddr,
   input  logic [7:0]          wdata,
   input  logic [UP_IDX_W-1:0] raddr,
   output logic [7:0]          rdata
);

   logic [7:0] mem [UP_PAL_DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/video_ulaplus_port.sv
// -----------------------------------------------------------------------------
// video_ulaplus_port
// Z80-side writer for the ULAplus palette and mode registers. Decodes accesses
// to #BF3B (register select) and #FF3B (data) into the mixer's up_* signals,
// holds a palette write pending while an ATM palette write owns the mixer,
// and serves 2-cycle-latency readback.
// Configuration:
//   ULAPLUS_READBACK_EN defined   -> shadow RAM + pending-write bypass readback
//   ULAPLUS_READBACK_EN undefined -> palette-group reads return 8'hFF
// Ports:
//   clk        in  1  28 MHz video clock
//   rst        in  1  synchronous active-high reset
//   port_wr    in  1  one-cycle write strobe
//   port_rd    in  1  one-cycle read strobe (dropped if port_wr also high)
//   port_sel   in  1  0 = #BF3B, 1 = #FF3B
//   din        in  8  CPU write data
//   atm_palwr  in  1  ATM palette write this cycle (wins in the mixer)
//   up_ena     out 1  ULAplus mode enable
//   up_palwr   out 1  palette write strobe to the mixer
//   up_paladdr out 6  palette entry index
//   up_paldata out 8  entry data GGGRRRBB
//   dout       out 8  readback data, holds between reads
//   rd_rdy     out 1  one-cycle pulse, dout valid
// -----------------------------------------------------------------------------
module video_ulaplus_port
   import video_ulaplus_port_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                port_wr,
   input  logic                port_rd,
   input  logic                port_sel,
   input  logic [7:0]          din,
   input  logic                atm_palwr,
   output logic                up_ena,
   output logic                up_palwr,
   output logic [UP_IDX_W-1:0] up_paladdr,
   output logic [7:0]          up_paldata,
   output logic [7:0]          dout,
   output logic                rd_rdy
);

   logic [7:0]          regsel_q,  regsel_d;
   logic                pend_q,    pend_d;
   logic                up_ena_q,  up_ena_d;
   logic [UP_IDX_W-1:0] paladdr_q, paladdr_d;
   logic [7:0]          paldata_q, paldata_d;

   // read pipeline stage 1 (aligned with the RAM output register)
   logic                rd1_vld_q,  rd1_vld_d;
   logic                rd1_ram_q,  rd1_ram_d;
   logic [7:0]          rd1_data_q, rd1_data_d;

   logic [7:0]          dout_q,   dout_d;
   logic                rd_rdy_q, rd_rdy_d;

   logic [1:0]          grp;
   logic [UP_IDX_W-1:0] idx;
   logic                palwr;
   logic                wr_reg;
   logic                wr_data;
   logic                rd_acc;
   logic [7:0]          ram_rdata;

   assign grp     = regsel_q[7:6];
   assign idx     = regsel_q[5:0];
   // Combinational so the commit yields in the very cycle ATM writes.
   assign palwr   = pend_q & ~atm_palwr;
   assign wr_reg  = port_wr & (port_sel == UP_SEL_REG);
   assign wr_data = port_wr & (port_sel == UP_SEL_DATA);
   assign rd_acc  = port_rd & ~port_wr;

`ifdef ULAPLUS_READBACK_EN
   video_ulaplus_shadow u_shadow (
      .clk   (clk),
      .we    (palwr),
      .waddr (paladdr_q),
      .wdata (paldata_q),
      .raddr (idx),
      .rdata (ram_rdata)
   );
`else
   assign ram_rdata = UP_RD_IDLE;
`endif

   always_comb begin
      regsel_d   = regsel_q;
      pend_d     = pend_q;
      up_ena_d   = up_ena_q;
      paladdr_d  = paladdr_q;
      paldata_d  = paldata_q;
      rd1_vld_d  = rd_acc;
      rd1_ram_d  = 1'b0;
      rd1_data_d = UP_RD_IDLE;
      rd_rdy_d   = rd1_vld_q;
      dout_d     = dout_q;

      if (wr_reg) begin
         regsel_d = din;
      end

      // Clear on commit first so a same-cycle data write re-arms pend.
      if (palwr) begin
         pend_d = 1'b0;
      end

      if (wr_data) begin
         case (grp)
            UP_GRP_PAL: begin
               paladdr_d = idx;
               paldata_d = din;
               pend_d    = 1'b1;
            end
            UP_GRP_MODE: up_ena_d = din[0];
            default: ;
         endcase
      end

      if (rd_acc && (port_sel == UP_SEL_DATA)) begin
         case (grp)
            UP_GRP_PAL: begin
`ifdef ULAPLUS_READBACK_EN
               // A pending entry is newer than the RAM copy.
               if (pend_q && (paladdr_q == idx)) begin
                  rd1_data_d = paldata_q;
               end else begin
                  rd1_ram_d = 1'b1;
               end
`endif
            end
            UP_GRP_MODE: rd1_data_d = {7'd0, up_ena_q};
            default: ;
         endcase
      end

      if (rd1_vld_q) begin
         dout_d = rd1_ram_q ? ram_rdata : rd1_data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regsel_q   <= 8'd0;
         pend_q     <= 1'b0;
         up_ena_q   <= 1'b0;
         paladdr_q  <= '0;
         paldata_q  <= 8'd0;
         rd1_vld_q  <= 1'b0;
         rd1_ram_q  <= 1'b0;
         rd1_data_q <= UP_RD_IDLE;
         dout_q     <= UP_RD_IDLE;
         rd_rdy_q   <= 1'b0;
      end else begin
         regsel_q   <= regsel_d;
         pend_q     <= pend_d;
         up_ena_q   <= up_ena_d;
         paladdr_q  <= paladdr_d;
         paldata_q  <= paldata_d;
         rd1_vld_q  <= rd1_vld_d;
         rd1_ram_q  <= rd1_ram_d;
         rd1_data_q <= rd1_data_d;
         dout_q     <= dout_d;
         rd_rdy_q   <= rd_rdy_d;
      end
   end

   assign up_ena     = up_ena_q;
   assign up_palwr   = palwr;
   assign up_paladdr = paladdr_q;
   assign up_paldata = paldata_q;
   assign dout       = dout_q;
   assign rd_rdy     = rd_rdy_q;

endmodule

// File: tb/tb_video_ulaplus_port.sv
// -----------------------------------------------------------------------------
// tb_video_ulaplus_port
// Each table row is one clock cycle: inputs are driven just after the rising
// edge and outputs are compared at the falling edge of the same cycle, so a
// row's expectations show the effect of earlier rows' writes plus the
// combinational commit against this row's atm_palwr.
// Readback expectations follow ULAPLUS_READBACK_EN.
// -----------------------------------------------------------------------------
module tb_video_ulaplus_port;

   logic       clk = 1'b0;
   logic       rst;
   logic       port_wr;
   logic       port_rd;
   logic       port_sel;
   logic [7:0] din;
   logic       atm_palwr;
   logic       up_ena;
   logic       up_palwr;
   logic [5:0] up_paladdr;
   logic [7:0] up_paldata;
   logic [7:0] dout;
   logic       rd_rdy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   video_ulaplus_port dut (
      .clk        (clk),
      .rst        (rst),
      .port_wr    (port_wr),
      .port_rd    (port_rd),
      .port_sel   (port_sel),
      .din        (din),
      .atm_palwr  (atm_palwr),
      .up_ena     (up_ena),
      .up_palwr   (up_palwr),
      .up_paladdr (up_paladdr),
      .up_paldata (up_paldata),
      .dout       (dout),
      .rd_rdy     (rd_rdy)
   );

   typedef struct {
      logic       wr;
      logic       rd;
      logic       sel;
      logic [7:0] din;
      logic       atm;
      logic       e_ena;
      logic       e_palwr;
      logic [5:0] e_addr;
      logic [7:0] e_data;
      logic       e_rdy;
      logic [7:0] e_dout;
   } vec_t;

   vec_t vq[$];

   // Expected palette-group read result.
   function automatic logic [7:0] rb(input logic [7:0] v);
`ifdef ULAPLUS_READBACK_EN
      return v;
`else
      return 8'hFF;
`endif
   endfunction

   task automatic add(input logic wr, input logic rd, input logic sel,
                      input logic [7:0] d, input logic atm,
                      input logic ena, input logic pw, input logic [5:0] a,
                      input logic [7:0] pd, input logic rdy, input logic [7:0] dv);
      vec_t v;
      v.wr = wr; v.rd = rd; v.sel = sel; v.din = d; v.atm = atm;
      v.e_ena = ena; v.e_palwr = pw; v.e_addr = a; v.e_data = pd;
      v.e_rdy = rdy; v.e_dout = dv;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic rd, input logic sel,
                        input logic [7:0] d, input logic atm);
      @(posedge clk);
      #1;
      port_wr = wr; port_rd = rd; port_sel = sel; din = d; atm_palwr = atm;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; port_wr = 0; port_rd = 0; port_sel = 0; din = 0; atm_palwr = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      //   wr rd sel din   atm | ena pw addr data  rdy dout
      add(0, 0, 0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 8'hFF);     // 0 reset state
      add(1, 0, 0, 8'h40, 0,   0, 0, 0, 8'h00, 0, 8'hFF);     // 1 select mode
      add(1, 0, 1, 8'h01, 0,   0, 0, 0, 8'h00, 0, 8'hFF);     // 2 ena=1
      add(0, 1, 1, 8'h00, 0,   1, 0, 0, 8'h00, 0, 8'hFF);     // 3 read mode
      add(0, 0, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 8'hFF);     // 4
      add(0, 0, 0, 8'h00, 0,   1, 0, 0, 8'h00, 1, 8'h01);     // 5 rd_rdy N+2
      add(1, 0, 0, 8'h05, 0,   1, 0, 0, 8'h00, 0, 8'h01);     // 6 select entry 5
      add(1, 0, 1, 8'hA7, 0,   1, 0, 0, 8'h00, 0, 8'h01);     // 7 data A7
      add(0, 0, 0, 8'h00, 0,   1, 1, 5, 8'hA7, 0, 8'h01);     // 8 commit
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'hA7, 0, 8'h01);     // 9 single pulse
      add(1, 0, 1, 8'h5A, 0,   1, 0, 5, 8'hA7, 0, 8'h01);     // 10 data 5A
      add(0, 0, 0, 8'h00, 1,   1, 0, 5, 8'h5A, 0, 8'h01);     // 11 ATM blocks
      add(0, 0, 0, 8'h00, 1,   1, 0, 5, 8'h5A, 0, 8'h01);     // 12
      add(0, 0, 0, 8'h00, 1,   1, 0, 5, 8'h5A, 0, 8'h01);     // 13
      add(0, 0, 0, 8'h00, 0,   1, 1, 5, 8'h5A, 0, 8'h01);     // 14 deferred commit
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h5A, 0, 8'h01);     // 15
      add(1, 0, 1, 8'h11, 1,   1, 0, 5, 8'h5A, 0, 8'h01);     // 16 entry5=11
      add(1, 0, 0, 8'h09, 1,   1, 0, 5, 8'h11, 0, 8'h01);     // 17 select 9
      add(1, 0, 1, 8'h22, 1,   1, 0, 5, 8'h11, 0, 8'h01);     // 18 entry9=22
      add(0, 0, 0, 8'h00, 1,   1, 0, 9, 8'h22, 0, 8'h01);     // 19 last wins
      add(0, 0, 0, 8'h00, 0,   1, 1, 9, 8'h22, 0, 8'h01);     // 20 one commit
      add(0, 0, 0, 8'h00, 0,   1, 0, 9, 8'h22, 0, 8'h01);     // 21
      add(1, 0, 0, 8'h05, 0,   1, 0, 9, 8'h22, 0, 8'h01);     // 22 select 5
      add(0, 1, 1, 8'h00, 0,   1, 0, 9, 8'h22, 0, 8'h01);     // 23 read entry 5
      add(0, 0, 0, 8'h00, 0,   1, 0, 9, 8'h22, 0, 8'h01);     // 24
      add(0, 0, 0, 8'h00, 0,   1, 0, 9, 8'h22, 1, rb(8'h5A)); // 25 never 11
      add(1, 0, 1, 8'h3C, 1,   1, 0, 9, 8'h22, 0, rb(8'h5A)); // 26 entry5=3C
      add(0, 1, 1, 8'h00, 1,   1, 0, 5, 8'h3C, 0, rb(8'h5A)); // 27 read (bypass)
      add(0, 0, 0, 8'h00, 0,   1, 1, 5, 8'h3C, 0, rb(8'h5A)); // 28 commit
      add(0, 1, 1, 8'h00, 0,   1, 0, 5, 8'h3C, 1, rb(8'h3C)); // 29 bypass data; read RAM
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 0, rb(8'h3C)); // 30
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 1, rb(8'h3C)); // 31 RAM data
      add(1, 0, 0, 8'h09, 0,   1, 0, 5, 8'h3C, 0, rb(8'h3C)); // 32 select 9
      add(0, 1, 1, 8'h00, 0,   1, 0, 5, 8'h3C, 0, rb(8'h3C)); // 33 read
      add(0, 1, 1, 8'h00, 0,   1, 0, 5, 8'h3C, 0, rb(8'h3C)); // 34 back-to-back
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 1, rb(8'h22)); // 35
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 1, rb(8'h22)); // 36
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 0, rb(8'h22)); // 37
      add(1, 0, 0, 8'h80, 0,   1, 0, 5, 8'h3C, 0, rb(8'h22)); // 38 group 10
      add(0, 1, 1, 8'h00, 0,   1, 0, 5, 8'h3C, 0, rb(8'h22)); // 39 read grp 10
      add(0, 1, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 0, rb(8'h22)); // 40 read #BF3B
      add(1, 0, 1, 8'h00, 0,   1, 0, 5, 8'h3C, 1, 8'hFF);     // 41 ignored write
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 1, 8'hFF);     // 42
      add(1, 1, 0, 8'h40, 0,   1, 0, 5, 8'h3C, 0, 8'hFF);     // 43 wr+rd: read dropped
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 0, 8'hFF);     // 44
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 0, 8'hFF);     // 45 no rd_rdy
      add(0, 1, 1, 8'h00, 0,   1, 0, 5, 8'h3C, 0, 8'hFF);     // 46 read mode
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 0, 8'hFF);     // 47
      add(0, 0, 0, 8'h00, 0,   1, 0, 5, 8'h3C, 1, 8'h01);     // 48
      add(1, 0, 1, 8'hFE, 0,   1, 0, 5, 8'h3C, 0, 8'h01);     // 49 ena=0
      add(0, 0, 0, 8'h00, 0,   0, 0, 5, 8'h3C, 0, 8'h01);     // 50

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].wr, vq[i].rd, vq[i].sel, vq[i].din, vq[i].atm);
         chk($sformatf("row%0d up_ena", i),     {7'd0, up_ena},   {7'd0, vq[i].e_ena});
         chk($sformatf("row%0d up_palwr", i),   {7'd0, up_palwr}, {7'd0, vq[i].e_palwr});
         chk($sformatf("row%0d up_paladdr", i), {2'd0, up_paladdr}, {2'd0, vq[i].e_addr});
         chk($sformatf("row%0d up_paldata", i), up_paldata,       vq[i].e_data);
         chk($sformatf("row%0d rd_rdy", i),     {7'd0, rd_rdy},   {7'd0, vq[i].e_rdy});
         chk($sformatf("row%0d dout", i),       dout,             vq[i].e_dout);
         $display("row %0d wr=%0b rd=%0b sel=%0b din=%h atm=%0b -> ena=%0b palwr=%0b addr=%0d data=%h rdy=%0b dout=%h",
                  i, vq[i].wr, vq[i].rd, vq[i].sel, vq[i].din, vq[i].atm,
                  up_ena, up_palwr, up_paladdr, up_paldata, rd_rdy, dout);
      end

      // Reset while a palette write is pending: the write must be lost.
      drive(1, 0, 0, 8'h40, 0);
      drive(1, 0, 1, 8'h01, 0);
      drive(1, 0, 0, 8'h05, 0);
      drive(1, 0, 1, 8'h77, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("pre_rst up_palwr",   {7'd0, up_palwr}, 8'd0);
      chk("pre_rst up_paldata", up_paldata, 8'h77);
      chk("pre_rst up_ena",     {7'd0, up_ena}, 8'd1);
      $display("reset asserted with entry 5 pending data=%h", up_paldata);
      @(posedge clk);
      #1 rst = 1'b0; atm_palwr = 1'b0; port_wr = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d up_palwr", c), {7'd0, up_palwr}, 8'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("post_rst up_ena",     {7'd0, up_ena}, 8'd0);
      chk("post_rst dout",       dout, 8'hFF);
      chk("post_rst rd_rdy",     {7'd0, rd_rdy}, 8'd0);
      chk("post_rst up_paladdr", {2'd0, up_paladdr}, 8'd0);
      chk("post_rst up_paldata", up_paldata, 8'h00);
      $display("post reset ena=%0b palwr=%0b dout=%h", up_ena, up_palwr, dout);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
